pc_sequencer: RTL and testbench

- Owns the fetch-address register and computes the next PC each cycle for the single-cycle MIPS core.
- Handles sequential fetch, branch, j/jal, jr/jalr, exception/interrupt entry, eret and stall.
- Holds EPC, Cause and the EXL bit, plus a small FSM that inserts a one-cycle flush bubble on every exception redirect.
- Drives the word address into the instruction memory; PC4 goes to the link-register write path.

---
 rtl/pc_sequencer_pkg.sv | 27 ++
 rtl/npc_calc.sv | 46 ++++
 rtl/pc_sequencer.sv | 116 +++++++++++
 tb/tb_pc_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared constants for the PC sequencer: fetch/handler addresses, exception codes, FSM encoding.
// Also provides the address-window helper used by the next-PC legality check.
package pc_sequencer_pkg;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] IM_BASE    = 32'h0000_3000;
  localparam int          IM_WORDS   = 1024;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  // True when addr falls inside a window of 'words' words starting at base.
  function automatic logic in_region(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input int          words);
    logic [31:0] last;
    last = base + 32'(words * 4) - 32'd4;
    return (addr >= base) && (addr <= last);
  endfunction

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC selection (eret, stall, jr, jump, branch, sequential) and AdEL detection.
// The flag covers misaligned targets and targets outside both instruction-memory windows.
module npc_calc #(
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] IM_BASE    = 32'h0000_3000,
  parameter int          IM_WORDS   = 1024
) (
  input  logic [31:0] pc_i,
  input  logic [31:0] epc_i,
  input  logic        exl_i,
  input  logic        eret_i,
  input  logic        stall_i,
  input  logic        jr_i,
  input  logic [31:0] jr_target_i,
  input  logic        jump_i,
  input  logic [25:0] j_index_i,
  input  logic        br_taken_i,
  input  logic [15:0] br_offset_i,
  output logic [31:0] pc4_o,
  output logic [31:0] npc_o,
  output logic        adel_o
);
  import pc_sequencer_pkg::*;

  logic [31:0] br_target;
  logic [31:0] j_target;
  logic        legal_window;

  assign pc4_o     = pc_i + 32'd4;
  assign br_target = pc4_o + {{14{br_offset_i[15]}}, br_offset_i, 2'b00};
  assign j_target  = {pc4_o[31:28], j_index_i, 2'b00};

  always_comb begin
    npc_o = pc4_o;
    if (eret_i && exl_i)  npc_o = epc_i;
    else if (stall_i)     npc_o = pc_i;
    else if (jr_i)        npc_o = jr_target_i;
    else if (jump_i)      npc_o = j_target;
    else if (br_taken_i)  npc_o = br_target;
  end

  assign legal_window = in_region(npc_o, IM_BASE, IM_WORDS) ||
                        in_region(npc_o, HANDLER_PC, IM_WORDS);
  assign adel_o       = (npc_o[1:0] != 2'b00) || !legal_window;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-address register with EPC/Cause/EXL and a RUN/FLUSH FSM for the single-cycle MIPS core.
// Every exception redirect is followed by one Flush cycle in which PC holds at the handler.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = pc_sequencer_pkg::RESET_PC,
  parameter logic [31:0] HANDLER_PC = pc_sequencer_pkg::HANDLER_PC,
  parameter logic [31:0] IM_BASE    = pc_sequencer_pkg::IM_BASE,
  parameter int          IM_WORDS   = pc_sequencer_pkg::IM_WORDS
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic        BrTaken,
  input  logic [15:0] BrOffset,
  input  logic        Jump,
  input  logic [25:0] JIndex,
  input  logic        Jr,
  input  logic [31:0] JrTarget,
  input  logic        ExcReq,
  input  logic [4:0]  ExcCodeIn,
  input  logic        IntReq,
  input  logic        IntEn,
  input  logic        Eret,
  output logic [31:0] PC,
  output logic [31:0] PC4,
  output logic [9:0]  IMAddr,
  output logic [31:0] EPC,
  output logic [4:0]  Cause,
  output logic        EXL,
  output logic        Flush
);
  import pc_sequencer_pkg::*;

  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic [4:0]  cause_q, cause_d;
  logic        exl_q, exl_d;
  logic [0:0]  state_q, state_d;

  logic [31:0] pc4;
  logic [31:0] npc;
  logic        adel;
  logic        int_take;
  logic        exc_take;

  npc_calc #(
    .HANDLER_PC (HANDLER_PC),
    .IM_BASE    (IM_BASE),
    .IM_WORDS   (IM_WORDS)
  ) u_npc_calc (
    .pc_i        (pc_q),
    .epc_i       (epc_q),
    .exl_i       (exl_q),
    .eret_i      (Eret),
    .stall_i     (Stall),
    .jr_i        (Jr),
    .jr_target_i (JrTarget),
    .jump_i      (Jump),
    .j_index_i   (JIndex),
    .br_taken_i  (BrTaken),
    .br_offset_i (BrOffset),
    .pc4_o       (pc4),
    .npc_o       (npc),
    .adel_o      (adel)
  );

  // Interrupts are masked while already in the handler; ExcReq is not.
  assign int_take = IntReq & IntEn & ~exl_q;
  assign exc_take = ExcReq | int_take | adel;

  always_comb begin
    pc_d    = pc_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    exl_d   = exl_q;
    state_d = ST_RUN;
    if (state_q == ST_RUN) begin
      if (exc_take) begin
        pc_d    = HANDLER_PC;
        epc_d   = pc_q;
        exl_d   = 1'b1;
        state_d = ST_FLUSH;
        if (ExcReq)        cause_d = ExcCodeIn;
        else if (int_take) cause_d = EXC_INT;
        else               cause_d = EXC_ADEL;
      end else begin
        pc_d = npc;
        if (Eret && exl_q) exl_d = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      pc_q    <= RESET_PC;
      epc_q   <= 32'd0;
      cause_q <= 5'd0;
      exl_q   <= 1'b0;
      state_q <= ST_RUN;
    end else begin
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      exl_q   <= exl_d;
      state_q <= state_d;
    end
  end

  assign PC     = pc_q;
  assign PC4    = pc4;
  assign IMAddr = pc_q[11:2];
  assign EPC    = epc_q;
  assign Cause  = cause_q;
  assign EXL    = exl_q;
  assign Flush  = (state_q == ST_FLUSH);

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table for the listed scenarios, then random traffic
// compared against an address-level model of the sequencing rules.
module tb_pc_sequencer;

  logic        Clk = 1'b0;
  logic        Rst, Stall, BrTaken, Jump, Jr, ExcReq, IntReq, IntEn, Eret;
  logic [15:0] BrOffset;
  logic [25:0] JIndex;
  logic [31:0] JrTarget;
  logic [4:0]  ExcCodeIn;
  logic [31:0] PC, PC4, EPC;
  logic [9:0]  IMAddr;
  logic [4:0]  Cause;
  logic        EXL, Flush;

  always #5 Clk = ~Clk;

  pc_sequencer dut (
    .Clk(Clk), .Rst(Rst), .Stall(Stall), .BrTaken(BrTaken), .BrOffset(BrOffset),
    .Jump(Jump), .JIndex(JIndex), .Jr(Jr), .JrTarget(JrTarget), .ExcReq(ExcReq),
    .ExcCodeIn(ExcCodeIn), .IntReq(IntReq), .IntEn(IntEn), .Eret(Eret),
    .PC(PC), .PC4(PC4), .IMAddr(IMAddr), .EPC(EPC), .Cause(Cause), .EXL(EXL), .Flush(Flush)
  );

  typedef struct {
    bit        rst, stall, br;
    bit [15:0] off;
    bit        jump;
    bit [25:0] jidx;
    bit        jr;
    bit [31:0] jrt;
    bit        exc;
    bit [4:0]  code;
    bit        intr, inten, eret;
  } in_t;

  localparam int OP_IDLE = 0, OP_RST = 1, OP_BR = 2, OP_J = 3, OP_JR = 4,
                 OP_EXC = 5, OP_ERET = 6, OP_STALL = 7, OP_STEXC = 8;

  typedef struct {
    int        op;
    bit [31:0] arg;
    bit        ih;
    bit [31:0] pc, epc;
    bit [4:0]  cause;
    bit        exl, fl;
  } row_t;

  localparam bit [31:0] A_RESET   = 32'h0000_3000;
  localparam bit [31:0] A_HANDLER = 32'h0000_4180;
  localparam int        WORDS     = 1024;

  int checks = 0;
  int errors = 0;

  bit [31:0] m_pc, m_epc;
  bit [4:0]  m_cause;
  bit        m_exl, m_flush;

  row_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit legal(input bit [31:0] a);
    bit in_im, in_h;
    in_im = (a >= A_RESET)   && (a < A_RESET + 4 * WORDS);
    in_h  = (a >= A_HANDLER) && (a < A_HANDLER + 4 * WORDS);
    return (a % 4 == 0) && (in_im || in_h);
  endfunction

  // Reference model: one architectural step per rising edge.
  task automatic model_step(input in_t v);
    bit [31:0] tgt;
    bit        irq;
    int        soff;
    if (v.rst) begin
      m_pc = A_RESET; m_epc = 0; m_cause = 0; m_exl = 0; m_flush = 0;
      return;
    end
    if (m_flush) begin
      m_flush = 0;
      return;
    end
    soff = $signed(v.off);
    if (v.eret && m_exl)  tgt = m_epc;
    else if (v.stall)     tgt = m_pc;
    else if (v.jr)        tgt = v.jrt;
    else if (v.jump)      tgt = ((m_pc + 4) & 32'hF000_0000) + v.jidx * 4;
    else if (v.br)        tgt = m_pc + 4 + soff * 4;
    else                  tgt = m_pc + 4;
    irq = v.intr && v.inten && !m_exl;
    if (v.exc || irq || !legal(tgt)) begin
      m_cause = v.exc ? v.code : (irq ? 5'd0 : 5'd4);
      m_epc   = m_pc;
      m_pc    = A_HANDLER;
      m_exl   = 1;
      m_flush = 1;
    end else begin
      m_pc = tgt;
      if (v.eret) m_exl = 0;
    end
  endtask

  task automatic apply(input in_t v);
    Rst = v.rst; Stall = v.stall; BrTaken = v.br; BrOffset = v.off;
    Jump = v.jump; JIndex = v.jidx; Jr = v.jr; JrTarget = v.jrt;
    ExcReq = v.exc; ExcCodeIn = v.code; IntReq = v.intr; IntEn = v.inten; Eret = v.eret;
    @(posedge Clk);
    model_step(v);
    @(negedge Clk);
  endtask

  task automatic check_model(input int n);
    chk($sformatf("rnd%0d.PC", n),     PC,     m_pc);
    chk($sformatf("rnd%0d.PC4", n),    PC4,    m_pc + 32'd4);
    chk($sformatf("rnd%0d.IMAddr", n), {22'd0, IMAddr}, (m_pc / 4) % 1024);
    chk($sformatf("rnd%0d.EPC", n),    EPC,    m_epc);
    chk($sformatf("rnd%0d.Cause", n),  {27'd0, Cause}, {27'd0, m_cause});
    chk($sformatf("rnd%0d.EXL", n),    {31'd0, EXL},   {31'd0, m_exl});
    chk($sformatf("rnd%0d.Flush", n),  {31'd0, Flush}, {31'd0, m_flush});
  endtask

  function automatic in_t mk(input int op, input bit [31:0] arg, input bit ih);
    in_t v;
    v = '{default: '0};
    v.intr  = ih;
    v.inten = ih;
    case (op)
      OP_RST:   v.rst = 1;
      OP_BR:    begin v.br = 1; v.off = arg[15:0]; end
      OP_J:     begin v.jump = 1; v.jidx = arg[25:0]; end
      OP_JR:    begin v.jr = 1; v.jrt = arg; end
      OP_EXC:   begin v.exc = 1; v.code = arg[4:0]; end
      OP_ERET:  v.eret = 1;
      OP_STALL: v.stall = 1;
      OP_STEXC: begin v.stall = 1; v.exc = 1; v.code = arg[4:0]; end
      default:  ;
    endcase
    return v;
  endfunction

  task automatic add(input int op, input bit [31:0] arg, input bit ih, input bit [31:0] pc,
                     input bit [31:0] epc, input bit [4:0] cause, input bit exl, input bit fl);
    row_t r;
    r.op = op; r.arg = arg; r.ih = ih; r.pc = pc; r.epc = epc;
    r.cause = cause; r.exl = exl; r.fl = fl;
    tbl.push_back(r);
  endtask

  initial begin
    in_t v;
    int  t;

    // Reset, idle fetch, eret with EXL=0 is sequential, branch/jump/jr targets
    add(OP_RST,   0,            0, 32'h3000, 0, 0, 0, 0);
    add(OP_IDLE,  0,            0, 32'h3004, 0, 0, 0, 0);
    add(OP_IDLE,  0,            0, 32'h3008, 0, 0, 0, 0);
    add(OP_IDLE,  0,            0, 32'h300C, 0, 0, 0, 0);
    add(OP_ERET,  0,            0, 32'h3010, 0, 0, 0, 0);
    add(OP_BR,    32'hFFFC,     0, 32'h3004, 0, 0, 0, 0);
    add(OP_J,     32'h0000C10,  0, 32'h3040, 0, 0, 0, 0);
    add(OP_JR,    32'h3100,     0, 32'h3100, 0, 0, 0, 0);
    add(OP_JR,    32'h3020,     0, 32'h3020, 0, 0, 0, 0);
    // Synchronous exception, redirect ignored during flush, eret
    add(OP_EXC,   12,           0, 32'h4180, 32'h3020, 12, 1, 1);
    add(OP_JR,    32'h3100,     0, 32'h4180, 32'h3020, 12, 1, 0);
    add(OP_IDLE,  0,            0, 32'h4184, 32'h3020, 12, 1, 0);
    add(OP_ERET,  0,            0, 32'h3020, 32'h3020, 12, 0, 0);
    // Level interrupt held through the handler, re-entry only after eret
    add(OP_JR,    32'h3008,     0, 32'h3008, 32'h3020, 12, 0, 0);
    add(OP_IDLE,  0,            1, 32'h4180, 32'h3008, 0, 1, 1);
    add(OP_IDLE,  0,            1, 32'h4180, 32'h3008, 0, 1, 0);
    add(OP_IDLE,  0,            1, 32'h4184, 32'h3008, 0, 1, 0);
    add(OP_IDLE,  0,            1, 32'h4188, 32'h3008, 0, 1, 0);
    add(OP_ERET,  0,            1, 32'h3008, 32'h3008, 0, 0, 0);
    add(OP_IDLE,  0,            1, 32'h4180, 32'h3008, 0, 1, 1);
    add(OP_IDLE,  0,            0, 32'h4180, 32'h3008, 0, 1, 0);
    add(OP_ERET,  0,            0, 32'h3008, 32'h3008, 0, 0, 0);
    // Misaligned jr target raises AdEL
    add(OP_JR,    32'h3010,     0, 32'h3010, 32'h3008, 0, 0, 0);
    add(OP_JR,    32'h3002,     0, 32'h4180, 32'h3010, 4, 1, 1);
    add(OP_IDLE,  0,            0, 32'h4180, 32'h3010, 4, 1, 0);
    add(OP_ERET,  0,            0, 32'h3010, 32'h3010, 4, 0, 0);
    // Stall holds, stall does not block an exception, reset during flush
    add(OP_JR,    32'h300C,     0, 32'h300C, 32'h3010, 4, 0, 0);
    add(OP_STALL, 0,            0, 32'h300C, 32'h3010, 4, 0, 0);
    add(OP_STALL, 0,            0, 32'h300C, 32'h3010, 4, 0, 0);
    add(OP_STALL, 0,            0, 32'h300C, 32'h3010, 4, 0, 0);
    add(OP_STEXC, 10,           0, 32'h4180, 32'h300C, 10, 1, 1);
    add(OP_RST,   0,            0, 32'h3000, 0, 0, 0, 0);
    // Nested synchronous exception overwrites EPC and Cause
    add(OP_IDLE,  0,            0, 32'h3004, 0, 0, 0, 0);
    add(OP_EXC,   10,           0, 32'h4180, 32'h3004, 10, 1, 1);
    add(OP_IDLE,  0,            0, 32'h4180, 32'h3004, 10, 1, 0);
    add(OP_EXC,   12,           0, 32'h4180, 32'h4180, 12, 1, 1);
    add(OP_IDLE,  0,            0, 32'h4180, 32'h4180, 12, 1, 0);
    // Out-of-window target raises AdEL
    add(OP_RST,   0,            0, 32'h3000, 0, 0, 0, 0);
    add(OP_JR,    32'h2000,     0, 32'h4180, 32'h3000, 4, 1, 1);
    add(OP_IDLE,  0,            0, 32'h4180, 32'h3000, 4, 1, 0);
    add(OP_RST,   0,            0, 32'h3000, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      apply(mk(tbl[i].op, tbl[i].arg, tbl[i].ih));
      chk($sformatf("row%0d.PC", i),     PC,     tbl[i].pc);
      chk($sformatf("row%0d.PC4", i),    PC4,    tbl[i].pc + 32'd4);
      chk($sformatf("row%0d.IMAddr", i), {22'd0, IMAddr}, {22'd0, tbl[i].pc[11:2]});
      chk($sformatf("row%0d.EPC", i),    EPC,    tbl[i].epc);
      chk($sformatf("row%0d.Cause", i),  {27'd0, Cause}, {27'd0, tbl[i].cause});
      chk($sformatf("row%0d.EXL", i),    {31'd0, EXL},   {31'd0, tbl[i].exl});
      chk($sformatf("row%0d.Flush", i),  {31'd0, Flush}, {31'd0, tbl[i].fl});
    end

    for (int n = 0; n < 3000; n++) begin
      v = '{default: '0};
      v.rst   = ($urandom_range(0, 199) == 0);
      v.stall = ($urandom_range(0, 7) == 0);
      v.br    = ($urandom_range(0, 3) == 0);
      t       = $urandom_range(0, 32);
      v.off   = 16'(t - 16);
      if ($urandom_range(0, 15) == 0) v.off = 16'($urandom);
      v.jump  = ($urandom_range(0, 5) == 0);
      v.jidx  = 26'($urandom_range(32'hC00, 32'hFFF));
      if ($urandom_range(0, 7) == 0) v.jidx = 26'($urandom);
      v.jr    = ($urandom_range(0, 5) == 0);
      v.jrt   = A_RESET + 4 * $urandom_range(0, WORDS - 1);
      case ($urandom_range(0, 9))
        0:       v.jrt = $urandom;
        1:       v.jrt = A_HANDLER + 4 * $urandom_range(0, WORDS - 1);
        2:       v.jrt = A_RESET + $urandom_range(0, 4095);
        default: ;
      endcase
      v.exc   = ($urandom_range(0, 19) == 0);
      v.code  = 5'($urandom);
      v.intr  = ($urandom_range(0, 5) == 0);
      v.inten = 1'($urandom);
      v.eret  = ($urandom_range(0, 7) == 0);
      apply(v);
      check_model(n);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
